sp_fifo: RTL and testbench

//  Parametrised serial-in/parallel-out FIFO: accepts one WIDTH-bit element per cycle, emits OUT elements per pop.

---
 rtl/sp_pkg.sv | 21 ++
 rtl/sp_word_gather.sv | 30 +++
 rtl/sp_fifo.sv | 114 +++++++++++
 tb/tb_sp_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out FIFO.
// Default geometry plus pointer-wrap and counter-width functions.
package sp_pkg;

  localparam int unsigned DEF_WIDTH = 32'd8;
  localparam int unsigned DEF_DEPTH = 32'd8;
  localparam int unsigned DEF_OUT   = 32'd2;
  localparam int unsigned OUT_W     = DEF_WIDTH * DEF_OUT;

  typedef int unsigned uint_t;

  function automatic uint_t cnt_bits(input uint_t depth);
    return $clog2(depth + 32'd1);
  endfunction

  // depth is a power of two, so masking is the modulo
  function automatic uint_t ptr_add(input uint_t ptr, input uint_t inc, input uint_t depth);
    return (ptr + inc) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/sp_word_gather.sv
// Assembles one output word from the storage window starting at r_ptr.
// Slot 0 (MS) is the oldest element; slots at or beyond vcnt are zero.
module sp_word_gather
  import sp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int OUT   = DEF_OUT
) (
  input  logic [WIDTH-1:0]            mem [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]    r_ptr,
  input  logic [$clog2(DEPTH+1)-1:0]  vcnt,
  output logic [WIDTH*OUT-1:0]        word
);

  localparam int PW = $clog2(DEPTH);

  // Window read with wrap across the end of storage
  always_comb begin
    word = '0;
    for (int k = 0; k < OUT; k++) begin
      if (k < 32'(vcnt)) begin
        word[WIDTH*(OUT-k)-1 -: WIDTH] = mem[PW'(ptr_add(32'(r_ptr), 32'(k), 32'(DEPTH)))];
      end else begin
        word[WIDTH*(OUT-k)-1 -: WIDTH] = '0;
      end
    end
  end

endmodule

// File: rtl/sp_fifo.sv
// Serial-in/parallel-out FIFO with valid/ready on both sides and exact occupancy.
// Define SP_FIFO_FLUSH_EN to add the flush port for zero-padded partial-word drain.
module sp_fifo
  import sp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int OUT   = DEF_OUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH*OUT-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]  count
`ifdef SP_FIFO_FLUSH_EN
  ,
  input  logic                        flush
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = int'(cnt_bits(32'(DEPTH)));

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    w_ptr_r;
  logic [PW-1:0]    r_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic [CW-1:0]    pop_n_s;
  logic [CW-1:0]    vcnt_s;
  logic             pend_s;
  logic             full_word_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;
`ifdef SP_FIFO_FLUSH_EN
  logic             flush_pend_r;
`endif

  // Handshake and next-occupancy decode from the pre-edge count
  always_comb begin
`ifdef SP_FIFO_FLUSH_EN
    pend_s = flush_pend_r;
`else
    pend_s = 1'b0;
`endif
    in_ready_s   = rst_n && (count_r < CW'(DEPTH)) && !pend_s;
    full_word_s  = (count_r >= CW'(OUT));
    out_valid_s  = full_word_s || (pend_s && (count_r != '0));
    pop_n_s      = full_word_s ? CW'(OUT) : count_r;
    vcnt_s       = out_valid_s ? pop_n_s : '0;
    push_s       = in_valid && in_ready_s;
    pop_s        = out_valid_s && out_ready;
    count_next_s = count_r + CW'(push_s) - (pop_s ? pop_n_s : '0);
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_r <= '0;
      r_ptr_r <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        w_ptr_r <= PW'(ptr_add(32'(w_ptr_r), 32'd1, 32'(DEPTH)));
      end
      if (pop_s) begin
        r_ptr_r <= PW'(ptr_add(32'(r_ptr_r), 32'(pop_n_s), 32'(DEPTH)));
      end
      count_r <= count_next_s;
    end
  end

`ifdef SP_FIFO_FLUSH_EN
  // Flush request latches only with data present; holds until the FIFO drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend_r <= 1'b0;
    end else if (flush_pend_r) begin
      flush_pend_r <= (count_next_s != '0);
    end else begin
      flush_pend_r <= flush && (count_r != '0) && (count_next_s != '0);
    end
  end
`endif

  // Element storage; not reset, contents are qualified by count
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[w_ptr_r] <= in_data;
    end
  end

  sp_word_gather #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .OUT   (OUT)
  ) u_gather (
    .mem   (mem_r),
    .r_ptr (r_ptr_r),
    .vcnt  (vcnt_s),
    .word  (out_data)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign count     = count_r;

endmodule

// File: tb/tb_sp_fifo.sv
// Self-checking bench for sp_fifo (WIDTH=8, DEPTH=4, OUT=2) with an element-queue model.
// Flush scenario is exercised when SP_FIFO_FLUSH_EN is defined.
module tb_sp_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  count;
`ifdef SP_FIFO_FLUSH_EN
  logic        flush;
`endif

  int checks;
  int failures;

  logic [7:0]  elem_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic        m_pend;

  sp_fifo #(.WIDTH(8), .DEPTH(4), .OUT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
`ifdef SP_FIFO_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_ov();
    return (elem_q.size() >= 2) || (m_pend && (elem_q.size() != 0));
  endfunction

  function automatic logic m_ir();
    return (elem_q.size() < 4) && !m_pend;
  endfunction

  function automatic logic [15:0] m_word();
    logic [15:0] w;
    w = 16'h0000;
    if (m_ov()) begin
      w[15:8] = elem_q[0];
      if (elem_q.size() >= 2) w[7:0] = elem_q[1];
    end
    return w;
  endfunction

  // One clock: drive, capture popped word at negedge, advance the model at posedge
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
    logic m_acc;
    logic m_pop;
    int   pre;
    int   n;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
`ifdef SP_FIFO_FLUSH_EN
    flush     = f;
`endif
    m_acc = v && m_ir();
    m_pop = r && m_ov();
    pre   = elem_q.size();
    @(negedge clk);
    if (m_pop) got_q.push_back(out_data);
    @(posedge clk);
    if (m_pop) begin
      exp_q.push_back(m_word());
      n = (pre >= 2) ? 2 : pre;
      repeat (n) void'(elem_q.pop_front());
    end
    if (m_acc) elem_q.push_back(d);
`ifdef SP_FIFO_FLUSH_EN
    if (m_pend) m_pend = (elem_q.size() != 0);
    else        m_pend = f && (pre != 0) && (elem_q.size() != 0);
`else
    if (f) m_pend = 1'b0;
`endif
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef SP_FIFO_FLUSH_EN
    flush     = 1'b0;
`endif
  endtask

  task automatic test_reset();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: count=%0d ov=%b od=%h ir=%b, need 0/0/0000/0", count, out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b need 1", in_ready);
    end
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd3) begin
      failures++;
      $display("FAIL reset_prefill_count: got %0d need 3", count);
    end
    rst_n = 1'b0;
    #1;
    elem_q.delete();
    m_pend = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_midstream: count=%0d ov=%b od=%h ir=%b, need 0/0/0000/0", count, out_valid, out_data, in_ready);
    end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || count !== 3'd0) begin
      failures++;
      $display("FAIL reset_after: ir=%b count=%0d need 1/0", in_ready, count);
    end
  endtask

  task automatic test_basic();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      failures++;
      $display("FAIL basic_one_elem: ov=%b od=%h need 0/0000", out_valid, out_data);
    end
    step(1'b1, 8'h22, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1122 || count !== 3'd2) begin
      failures++;
      $display("FAIL basic_word: ov=%b od=%h count=%0d need 1/1122/2", out_valid, out_data, count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_pop: count=%0d ov=%b need 0/0", count, out_valid);
    end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      logic [15:0] g;
      logic [15:0] e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL basic_sb: got %h need %h", g, e);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || count !== 3'd4) begin
      failures++;
      $display("FAIL fill_full: ir=%b count=%0d need 0/4", in_ready, count);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (count !== 3'(elem_q.size()) || out_data !== m_word()) begin
      failures++;
      $display("FAIL fill_drop: count=%0d od=%h need %0d/%h", count, out_data, elem_q.size(), m_word());
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hB0, 1'b0, 1'b0);
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hA2A3) begin
        failures++;
        $display("FAIL wrap_hold%0d: ov=%b od=%h need 1/a2a3", i, out_valid, out_data);
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd0 || got_q.size() != 3) begin
      failures++;
      $display("FAIL wrap_drain: count=%0d pops=%0d need 0/3", count, got_q.size());
    end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      logic [15:0] g;
      logic [15:0] e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL wrap_sb: got %h need %h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'hD0, 1'b0, 1'b0);
    step(1'b1, 8'hD1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hD2 + 8'(i), 1'b1, 1'b0);
      checks++;
      if (count !== 3'(elem_q.size()) || count > 3'd4) begin
        failures++;
        $display("FAIL b2b_count%0d: got %0d need %0d", i, count, elem_q.size());
      end
    end
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      logic [15:0] g;
      logic [15:0] e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL b2b_sb: got %h need %h", g, e);
      end
    end
    checks++;
    if (count !== 3'(elem_q.size())) begin
      failures++;
      $display("FAIL b2b_final_count: got %0d need %0d", count, elem_q.size());
    end
  endtask

`ifdef SP_FIFO_FLUSH_EN
  task automatic test_flush();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty: ir=%b ov=%b need 1/0", in_ready, out_valid);
    end
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_block: ir=%b need 0", in_ready);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hC200 || count !== 3'd1) begin
      failures++;
      $display("FAIL flush_partial: ov=%b od=%h count=%0d need 1/c200/1", out_valid, out_data, count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_done: count=%0d ir=%b ov=%b need 0/1/0", count, in_ready, out_valid);
    end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      logic [15:0] g;
      logic [15:0] e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL flush_sb: got %h need %h", g, e);
      end
    end
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    m_pend    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef SP_FIFO_FLUSH_EN
    flush     = 1'b0;
`endif
    #12;
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_back_to_back();
`ifdef SP_FIFO_FLUSH_EN
    test_flush();
`endif
    checks++;
    if (got_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got_q=%0d exp_q=%0d need 0/0", got_q.size(), exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
